// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/ready channel and the
// valid/accept channel that hands fetched instructions to decode.
interface pc_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_accept;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_data,
    output instr_valid,
    input  instr_accept,
    output instr_out,
    output instr_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_data,
    input  instr_valid,
    output instr_accept,
    input  instr_out,
    input  instr_pc
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC holder and single-outstanding instruction fetch sequencer,
// with redirect squash, halt gating and delivered-instruction counting.
module pc_fetch_sequencer #(
  parameter logic [31:0] ResetPc = 32'h0000_0000,
  parameter logic [31:0] PcStep  = 32'd4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_target,
  input  logic                         halt,
  pc_fetch_sequencer_if.master         bus,
  output logic [31:0]                  cur_pc,
  output logic                         misalign_err,
  output logic [31:0]                  fetch_count
);

  typedef enum logic [1:0] {StIdle, StReq, StDeliver, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_pc_q, cur_pc_d;
  logic        bubble_q, bubble_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        imem_req;
  logic        fetch_done;
  logic        deliver_done;

  // A redirect leaves one request-free cycle so memory sees the old request withdrawn.
  assign imem_req     = (state_q == StReq) && !bubble_q;
  assign fetch_done   = imem_req && bus.imem_ready;
  assign deliver_done = (state_q == StDeliver) && bus.instr_accept;

  always_comb begin
    state_d       = state_q;
    cur_pc_d      = cur_pc_q;
    bubble_d      = 1'b0;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    if (redirect_valid) begin
      cur_pc_d      = {redirect_target[31:2], 2'b00};
      instr_valid_d = 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
      if (state_q != StHalted) begin
        state_d  = StReq;
        bubble_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = halt ? StHalted : StReq;
        end
        StReq: begin
          if (fetch_done) begin
            instr_out_d   = bus.imem_data;
            instr_pc_d    = cur_pc_q;
            instr_valid_d = 1'b1;
            cur_pc_d      = cur_pc_q + PcStep;
            state_d       = StDeliver;
          end
        end
        StDeliver: begin
          if (deliver_done) begin
            instr_valid_d = 1'b0;
            fetch_count_d = fetch_count_q + 32'd1;
            state_d       = halt ? StHalted : StReq;
          end
        end
        StHalted: begin
          if (!halt) begin
            state_d = StReq;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cur_pc_q      <= ResetPc;
      bubble_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_out_q   <= 32'h0;
      instr_pc_q    <= 32'h0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      cur_pc_q      <= cur_pc_d;
      bubble_q      <= bubble_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = cur_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
  assign cur_pc          = cur_pc_q;
  assign misalign_err    = misalign_q;
  assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: fetched words are queued as they are
// returned by the memory model and compared when decode accepts them.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic [31:0] cur_pc;
  logic        misalign_err;
  logic [31:0] fetch_count;

  pc_fetch_sequencer_if ifc ();

  pc_fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .bus             (ifc.master),
    .cur_pc          (cur_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic use_fixed = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Evaluate the handshakes that fire at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (!use_fixed) ifc.imem_data = mem_word(ifc.imem_addr);
    if (ifc.imem_req && ifc.imem_ready && !redirect_valid)
      sb.push_back({ifc.imem_addr, ifc.imem_data});
    if (ifc.instr_valid && ifc.instr_accept) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (!redirect_valid) begin
          chk("instr_pc", ifc.instr_pc, e.pc);
          chk("instr_out", ifc.instr_out, e.data);
        end
      end
    end else if (ifc.instr_valid && redirect_valid && sb.size() != 0) begin
      e = sb.pop_front();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_target  = 32'h0;
    halt             = 1'b0;
    ifc.imem_ready   = 1'b0;
    ifc.imem_data    = 32'h0;
    ifc.instr_accept = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("rst_pc", cur_pc, 32'h0);
    chk("rst_out", ifc.instr_out, 32'h0);
    chk("rst_ipc", ifc.instr_pc, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);

    // 1: ready and accept always high, sequential fetches on alternate cycles
    rst_n = 1'b1;
    ifc.imem_ready   = 1'b1;
    ifc.instr_accept = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("t1_req", {31'd0, ifc.imem_req}, 32'd1);
      chk("t1_addr", ifc.imem_addr, 32'(4 * k));
      tick();
      chk("t1_valid", {31'd0, ifc.instr_valid}, 32'd1);
      chk("t1_noreq", {31'd0, ifc.imem_req}, 32'd0);
      tick();
    end
    chk("t1_cnt", fetch_count, 32'd3);

    // 2: memory stalls five cycles, request must stay stable
    ifc.imem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t2_req", {31'd0, ifc.imem_req}, 32'd1);
      chk("t2_addr", ifc.imem_addr, 32'hC);
      tick();
    end
    use_fixed      = 1'b1;
    ifc.imem_data  = 32'hDEAD_BEEF;
    ifc.imem_ready = 1'b1;
    tick();
    chk("t2_valid", {31'd0, ifc.instr_valid}, 32'd1);
    chk("t2_data", ifc.instr_out, 32'hDEAD_BEEF);
    tick();
    use_fixed = 1'b0;
    chk("t2_cnt", fetch_count, 32'd4);

    // 3: redirect while request pending, then redirect colliding with ready
    ifc.imem_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_bubble", {31'd0, ifc.imem_req}, 32'd0);
    chk("t3_pc", cur_pc, 32'h100);
    tick();
    chk("t3_req", {31'd0, ifc.imem_req}, 32'd1);
    chk("t3_addr", ifc.imem_addr, 32'h100);
    ifc.imem_ready  = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    ifc.imem_ready = 1'b0;
    chk("t3_discard", {31'd0, ifc.instr_valid}, 32'd0);
    chk("t3_nostep", cur_pc, 32'h200);
    tick();
    chk("t3_addr2", ifc.imem_addr, 32'h200);

    // 4: redirect squashes a delivery even with accept in the same cycle
    ifc.imem_ready = 1'b1;
    tick();
    ifc.imem_ready = 1'b0;
    chk("t4_valid", {31'd0, ifc.instr_valid}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("t4_squash", {31'd0, ifc.instr_valid}, 32'd0);
    chk("t4_cnt", fetch_count, 32'd4);
    tick();
    chk("t4_addr", ifc.imem_addr, 32'h300);

    // 5: misaligned target is forced aligned and flagged; PC wraps past top
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    tick();
    chk("t5_pc", cur_pc, 32'h100);
    chk("t5_mis", {31'd0, misalign_err}, 32'd1);
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("t5_top", ifc.imem_addr, 32'hFFFF_FFFC);
    ifc.imem_ready = 1'b1;
    tick();
    ifc.imem_ready = 1'b0;
    chk("t5_wrap", cur_pc, 32'h0);
    chk("t5_ipc", ifc.instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("t5_cnt", fetch_count, 32'd5);
    chk("t5_sticky", {31'd0, misalign_err}, 32'd1);

    // 6: halt lets the current fetch finish, then parks; resumes at redirected PC
    halt             = 1'b1;
    ifc.instr_accept = 1'b0;
    tick();
    chk("t6_req", {31'd0, ifc.imem_req}, 32'd1);
    ifc.imem_ready = 1'b1;
    tick();
    ifc.imem_ready = 1'b0;
    tick();
    chk("t6_hold", {31'd0, ifc.instr_valid}, 32'd1);
    ifc.instr_accept = 1'b1;
    tick();
    chk("t6_halted", {31'd0, ifc.imem_req}, 32'd0);
    chk("t6_cnt", fetch_count, 32'd6);
    tick();
    chk("t6_park", {31'd0, ifc.imem_req}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    tick();
    redirect_valid = 1'b0;
    chk("t6_hpc", cur_pc, 32'h400);
    chk("t6_hreq", {31'd0, ifc.imem_req}, 32'd0);
    halt = 1'b0;
    tick();
    chk("t6_resume", {31'd0, ifc.imem_req}, 32'd1);
    chk("t6_raddr", ifc.imem_addr, 32'h400);

    // Async reset mid-request
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("ar_pc", cur_pc, 32'h0);
    chk("ar_mis", {31'd0, misalign_err}, 32'd0);
    chk("ar_cnt", fetch_count, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.instr_accept = 1'b0;
    tick();
    chk("ar_restart", ifc.imem_addr, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
